// File: rtl/por_cfg_loader.sv
// Power-on configuration loader: reads a magic word and NUM_WORDS config words from EEPROM.
// Optional trailing checksum word enabled by macro POR_CFG_CHECKSUM_EN.
module por_cfg_loader #(
  parameter int unsigned NUM_WORDS = 4,
  parameter int unsigned RD_WAIT   = 16,
  parameter int unsigned CLR_CYC   = 16,
  parameter int unsigned MAX_RETRY = 2,
  parameter logic [31:0] MAGIC     = 32'h3111_1511,
  parameter logic [15:0] BASE_ADDR = 16'hFFC0
) (
  input  logic        timer_clk,
  input  logic        por_rst_n,
  input  logic        test_en,
  input  logic        spi_en_s,
  input  logic        spi_en_s_val,
  input  logic [31:0] por_ee_data_e2l,
  output logic        por_rd_en,
  output logic        por_vs_en,
  output logic        por_tc_sel,
  output logic        por_clr_dl,
  output logic [15:0] por_ee_addr,
  output logic        cfg_word_vld,
  output logic [2:0]  cfg_word_idx,
  output logic [31:0] cfg_word_data,
  output logic        spien_bit,
  output logic [2:0]  por_retry_cnt,
  output logic        por_cfg_done,
  output logic        por_cfg_err,
  output logic        por_cfg_done_r
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_MAG_RD   = 4'd1;
  localparam logic [3:0] S_MAG_GAP  = 4'd2;
  localparam logic [3:0] S_MAG_CHK  = 4'd3;
  localparam logic [3:0] S_TEST_DET = 4'd4;
  localparam logic [3:0] S_MODE_DET = 4'd5;
  localparam logic [3:0] S_IF_SETUP = 4'd6;
  localparam logic [3:0] S_WRD_RD   = 4'd7;
  localparam logic [3:0] S_WRD_GAP  = 4'd8;
  localparam logic [3:0] S_WRD_CAP  = 4'd9;
  localparam logic [3:0] S_SUM_CHK  = 4'd10;
  localparam logic [3:0] S_RETRY    = 4'd11;
  localparam logic [3:0] S_DONE     = 4'd12;
  localparam logic [3:0] S_ERR      = 4'd13;

  localparam logic [6:0] CLR_N     = 7'(CLR_CYC);
  localparam logic [6:0] RD_LAST   = 7'(RD_WAIT - 1);
  localparam logic [3:0] LAST_WORD = 4'(NUM_WORDS - 1);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRY);

  logic        r_test_m, r_test_s;
  logic        r_spi_m, r_spi_s;
  logic        r_val_m, r_val_s;

  logic [3:0]  r_state;
  logic [6:0]  r_cnt;
  logic [3:0]  r_idx;
  logic [31:0] r_rdata;
  logic        r_rd_en, r_vs_en, r_tc_sel, r_clr_dl;
  logic [15:0] r_addr;
  logic        r_vld;
  logic [2:0]  r_vld_idx;
  logic [31:0] r_vld_data;
  logic        r_spien;
  logic [2:0]  r_retry;
  logic        r_done, r_err, r_done_d1, r_done_d2;
`ifdef POR_CFG_CHECKSUM_EN
  logic [31:0] r_sum;
`endif

  logic [3:0]  w_retry_inc;
  logic        w_retry_ovf;

  // Compare against the unsaturated increment so MAX_RETRY=7 still terminates.
  assign w_retry_inc = {1'b0, r_retry} + 4'd1;
  assign w_retry_ovf = (w_retry_inc > RETRY_MAX);

  function automatic logic [15:0] f_addr(input logic [3:0] k);
    return BASE_ADDR + {10'd0, k, 2'b00};
  endfunction

  always_ff @(posedge timer_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      r_test_m <= 1'b0;
      r_test_s <= 1'b0;
      r_spi_m  <= 1'b0;
      r_spi_s  <= 1'b0;
      r_val_m  <= 1'b0;
      r_val_s  <= 1'b0;
    end else begin
      r_test_m <= test_en;
      r_test_s <= r_test_m;
      r_spi_m  <= spi_en_s;
      r_spi_s  <= r_spi_m;
      r_val_m  <= spi_en_s_val;
      r_val_s  <= r_val_m;
    end
  end

  always_ff @(posedge timer_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_idx      <= '0;
      r_rdata    <= '0;
      r_rd_en    <= 1'b0;
      r_vs_en    <= 1'b0;
      r_tc_sel   <= 1'b0;
      r_clr_dl   <= 1'b0;
      r_addr     <= BASE_ADDR;
      r_vld      <= 1'b0;
      r_vld_idx  <= '0;
      r_vld_data <= '0;
      r_spien    <= 1'b0;
      r_retry    <= '0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
`ifdef POR_CFG_CHECKSUM_EN
      r_sum      <= '0;
`endif
    end else begin
      r_vld <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (r_cnt < CLR_N) begin
            r_clr_dl <= 1'b1;
            r_cnt    <= r_cnt + 7'd1;
          end else begin
            r_clr_dl <= 1'b0;
            r_cnt    <= '0;
            r_vs_en  <= 1'b1;
            r_tc_sel <= 1'b1;
            r_rd_en  <= 1'b1;
            r_addr   <= BASE_ADDR;
            r_state  <= S_MAG_RD;
          end
        end
        S_MAG_RD, S_WRD_RD: begin
          if (r_cnt == RD_LAST) begin
            r_rd_en <= 1'b0;
            r_cnt   <= '0;
            r_state <= (r_state == S_MAG_RD) ? S_MAG_GAP : S_WRD_GAP;
          end else begin
            r_cnt <= r_cnt + 7'd1;
          end
        end
        S_MAG_GAP: begin
          r_rdata <= por_ee_data_e2l;
          r_state <= S_MAG_CHK;
        end
        S_MAG_CHK: begin
          if (r_rdata == MAGIC) begin
            r_idx   <= '0;
            r_addr  <= f_addr(4'd1);
            r_rd_en <= 1'b1;
`ifdef POR_CFG_CHECKSUM_EN
            r_sum   <= '0;
`endif
            r_state <= S_WRD_RD;
          end else if (r_test_s) begin
            r_state <= S_TEST_DET;
          end else begin
            r_state <= S_RETRY;
          end
        end
        S_TEST_DET: r_state <= S_MODE_DET;
        S_MODE_DET: if (r_val_s) r_state <= S_IF_SETUP;
        S_IF_SETUP: begin
          r_spien  <= r_spi_s;
          r_rd_en  <= 1'b0;
          r_vs_en  <= 1'b0;
          r_tc_sel <= 1'b0;
          r_done   <= 1'b1;
          r_err    <= 1'b0;
          r_state  <= S_DONE;
        end
        // Strobe is registered here so it is high exactly while in WRD_CAP.
        S_WRD_GAP: begin
          r_rdata <= por_ee_data_e2l;
          r_state <= S_WRD_CAP;
          if (r_idx <= LAST_WORD) begin
            r_vld      <= 1'b1;
            r_vld_idx  <= r_idx[2:0];
            r_vld_data <= por_ee_data_e2l;
            if (r_idx == 4'd0) r_spien <= |por_ee_data_e2l[25:24];
          end
        end
        S_WRD_CAP: begin
`ifdef POR_CFG_CHECKSUM_EN
          r_sum <= r_sum + r_rdata;
          if (r_idx <= LAST_WORD) begin
            r_idx   <= r_idx + 4'd1;
            r_addr  <= f_addr(r_idx + 4'd2);
            r_rd_en <= 1'b1;
            r_state <= S_WRD_RD;
          end else begin
            r_state <= S_SUM_CHK;
          end
`else
          if (r_idx < LAST_WORD) begin
            r_idx   <= r_idx + 4'd1;
            r_addr  <= f_addr(r_idx + 4'd2);
            r_rd_en <= 1'b1;
            r_state <= S_WRD_RD;
          end else begin
            r_rd_en  <= 1'b0;
            r_vs_en  <= 1'b0;
            r_tc_sel <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end
`endif
        end
        S_SUM_CHK: begin
`ifdef POR_CFG_CHECKSUM_EN
          if (r_sum == 32'd0) begin
            r_rd_en  <= 1'b0;
            r_vs_en  <= 1'b0;
            r_tc_sel <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_DONE;
          end else begin
            r_state <= S_RETRY;
          end
`else
          r_rd_en  <= 1'b0;
          r_vs_en  <= 1'b0;
          r_tc_sel <= 1'b0;
          r_done   <= 1'b1;
          r_err    <= 1'b1;
          r_state  <= S_ERR;
`endif
        end
        S_RETRY: begin
          r_retry <= w_retry_inc[3] ? 3'd7 : w_retry_inc[2:0];
          if (w_retry_ovf) begin
            r_rd_en  <= 1'b0;
            r_vs_en  <= 1'b0;
            r_tc_sel <= 1'b0;
            r_done   <= 1'b1;
            r_err    <= 1'b1;
            r_state  <= S_ERR;
          end else begin
            r_cnt   <= '0;
            r_addr  <= BASE_ADDR;
            r_rd_en <= 1'b1;
            r_state <= S_MAG_RD;
          end
        end
        S_DONE, S_ERR: r_state <= r_state;
        default: begin
          r_rd_en  <= 1'b0;
          r_vs_en  <= 1'b0;
          r_tc_sel <= 1'b0;
          r_done   <= 1'b1;
          r_err    <= 1'b1;
          r_state  <= S_ERR;
        end
      endcase
    end
  end

  always_ff @(posedge timer_clk or negedge por_rst_n) begin
    if (!por_rst_n) begin
      r_done_d1 <= 1'b0;
      r_done_d2 <= 1'b0;
    end else begin
      r_done_d1 <= r_done;
      r_done_d2 <= r_done_d1;
    end
  end

  assign por_rd_en      = r_rd_en;
  assign por_vs_en      = r_vs_en;
  assign por_tc_sel     = r_tc_sel;
  assign por_clr_dl     = r_clr_dl;
  assign por_ee_addr    = r_addr;
  assign cfg_word_vld   = r_vld;
  assign cfg_word_idx   = r_vld_idx;
  assign cfg_word_data  = r_vld_data;
  assign spien_bit      = r_spien;
  assign por_retry_cnt  = r_retry;
  assign por_cfg_done   = r_done;
  assign por_cfg_err    = r_err;
  assign por_cfg_done_r = r_done_d2;

endmodule

// File: tb/tb_por_cfg_loader.sv
// Scoreboard bench for por_cfg_loader: expected reads and word strobes are queued by the
// scenarios and consumed by independent monitors; EEPROM is a small address-decoded array.
module tb_por_cfg_loader;

  localparam logic [15:0] BASE  = 16'hFFC0;
  localparam logic [31:0] MAGIC = 32'h3111_1511;

  logic        timer_clk = 1'b0;
  logic        por_rst_n = 1'b0;
  logic        test_en = 1'b0;
  logic        spi_en_s = 1'b0;
  logic        spi_en_s_val = 1'b0;
  logic [31:0] por_ee_data_e2l;
  logic        por_rd_en, por_vs_en, por_tc_sel, por_clr_dl;
  logic [15:0] por_ee_addr;
  logic        cfg_word_vld;
  logic [2:0]  cfg_word_idx;
  logic [31:0] cfg_word_data;
  logic        spien_bit;
  logic [2:0]  por_retry_cnt;
  logic        por_cfg_done, por_cfg_err, por_cfg_done_r;

  por_cfg_loader #(
    .NUM_WORDS(4), .RD_WAIT(16), .CLR_CYC(16), .MAX_RETRY(2),
    .MAGIC(MAGIC), .BASE_ADDR(BASE)
  ) dut (
    .timer_clk(timer_clk), .por_rst_n(por_rst_n), .test_en(test_en),
    .spi_en_s(spi_en_s), .spi_en_s_val(spi_en_s_val),
    .por_ee_data_e2l(por_ee_data_e2l), .por_rd_en(por_rd_en),
    .por_vs_en(por_vs_en), .por_tc_sel(por_tc_sel), .por_clr_dl(por_clr_dl),
    .por_ee_addr(por_ee_addr), .cfg_word_vld(cfg_word_vld),
    .cfg_word_idx(cfg_word_idx), .cfg_word_data(cfg_word_data),
    .spien_bit(spien_bit), .por_retry_cnt(por_retry_cnt),
    .por_cfg_done(por_cfg_done), .por_cfg_err(por_cfg_err),
    .por_cfg_done_r(por_cfg_done_r)
  );

  always #5 timer_clk = ~timer_clk;

  // EEPROM image: [0]=magic, [1..4]=config words, [5]=checksum word
  logic [31:0] mem [0:5];
  logic [15:0] ee_off;
  assign ee_off = por_ee_addr - BASE;
  assign por_ee_data_e2l = (ee_off[1:0] == 2'b00 && ee_off < 16'd24) ? mem[ee_off[4:2]] : 32'hDEAD_BEEF;

  int n_chk = 0;
  int n_err = 0;
  logic [15:0] q_rd [$];
  logic [34:0] q_vld [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Read monitor: run length, address stability through the gap, expected address
  initial begin
    int run;
    logic [15:0] run_addr;
    logic moved;
    run = 0; run_addr = '0; moved = 1'b0;
    forever begin
      @(negedge timer_clk);
      if (!por_rst_n) begin
        run = 0;
      end else if (por_rd_en) begin
        if (run == 0) begin
          run_addr = por_ee_addr;
          moved = 1'b0;
          check("rd_vs_tc_high", {30'd0, por_vs_en, por_tc_sel}, 32'd3);
        end else if (por_ee_addr !== run_addr) begin
          moved = 1'b1;
        end
        run++;
      end else if (run > 0) begin
        check("rd_len", run, 16);
        check("rd_addr_stable", {15'd0, moved, por_ee_addr}, {16'd0, run_addr});
        if (q_rd.size() == 0) check("rd_unexpected", {16'd0, run_addr}, 32'hFFFF_FFFF);
        else check("rd_addr", {16'd0, run_addr}, {16'd0, q_rd.pop_front()});
        run = 0;
      end
    end
  end

  // Word-strobe monitor
  initial begin
    logic prev;
    logic [34:0] e;
    prev = 1'b0;
    forever begin
      @(negedge timer_clk);
      if (!por_rst_n) begin
        prev = 1'b0;
      end else begin
        if (cfg_word_vld) begin
          check("vld_width", {31'd0, prev}, 32'd0);
          if (q_vld.size() == 0) begin
            check("vld_unexpected", {29'd0, cfg_word_idx}, 32'hFFFF_FFFF);
          end else begin
            e = q_vld.pop_front();
            check("vld_idx", {29'd0, cfg_word_idx}, {29'd0, e[34:32]});
            check("vld_data", cfg_word_data, e[31:0]);
          end
        end
        prev = cfg_word_vld;
      end
    end
  end

  // Data-latch clear pulse length after each reset release
  initial begin
    int crun;
    crun = 0;
    forever begin
      @(negedge timer_clk);
      if (!por_rst_n) crun = 0;
      else if (por_clr_dl) crun++;
      else if (crun > 0) begin
        check("clr_len", crun, 16);
        crun = 0;
      end
    end
  end

  task automatic set_mem(input logic [31:0] mg, input logic [31:0] w0, input logic [31:0] w1,
                         input logic [31:0] w2, input logic [31:0] w3);
    mem[0] = mg; mem[1] = w0; mem[2] = w1; mem[3] = w2; mem[4] = w3;
    mem[5] = 32'd0 - (w0 + w1 + w2 + w3);
  endtask

  task automatic push_attempt(input logic magic_ok);
    q_rd.push_back(BASE);
    if (magic_ok) begin
      for (int i = 0; i < 4; i++) begin
        q_rd.push_back(BASE + 16'(4 * (i + 1)));
        q_vld.push_back({3'(i), mem[i + 1]});
      end
`ifdef POR_CFG_CHECKSUM_EN
      q_rd.push_back(BASE + 16'd20);
`endif
    end
  endtask

  task automatic do_reset(input string tag);
    por_rst_n = 1'b0;
    repeat (3) @(posedge timer_clk);
    #1;
    check({tag, "_rst_strobes"}, {25'd0, por_rd_en, por_vs_en, por_tc_sel, por_clr_dl,
          cfg_word_vld, por_cfg_done, por_cfg_err}, 32'd0);
    check({tag, "_rst_addr"}, {16'd0, por_ee_addr}, {16'd0, BASE});
    check({tag, "_rst_misc"}, {25'd0, spien_bit, por_retry_cnt, por_cfg_done_r, cfg_word_idx[1:0]}, 32'd0);
    @(negedge timer_clk);
    por_rst_n = 1'b1;
  endtask

  task automatic wait_done(input string tag);
    int i;
    for (i = 0; i < 3000; i++) begin
      @(negedge timer_clk);
      if (por_cfg_done) break;
    end
    check({tag, "_done"}, {31'd0, por_cfg_done}, 32'd1);
    check({tag, "_done_r_lag"}, {31'd0, por_cfg_done_r}, 32'd0);
    @(negedge timer_clk);
    @(negedge timer_clk);
    check({tag, "_done_r"}, {31'd0, por_cfg_done_r}, 32'd1);
  endtask

  task automatic final_checks(input string tag, input logic err, input logic [2:0] retry, input logic spien);
    check({tag, "_err"}, {31'd0, por_cfg_err}, {31'd0, err});
    check({tag, "_retry"}, {29'd0, por_retry_cnt}, {29'd0, retry});
    check({tag, "_spien"}, {31'd0, spien_bit}, {31'd0, spien});
    check({tag, "_eeprom_off"}, {29'd0, por_rd_en, por_vs_en, por_tc_sel}, 32'd0);
    check({tag, "_rd_q_empty"}, q_rd.size(), 0);
    check({tag, "_vld_q_empty"}, q_vld.size(), 0);
    q_rd.delete();
    q_vld.delete();
  endtask

  initial begin
    int i;
    // S1: normal load, words 1..4
    set_mem(MAGIC, 32'd1, 32'd2, 32'd3, 32'd4);
    push_attempt(1'b1);
    do_reset("s1");
    wait_done("s1");
    final_checks("s1", 1'b0, 3'd0, 1'b0);

    // S2: reset during the third read cycle of config word 2, then full reload
    set_mem(MAGIC, 32'h0100_0001, 32'd2, 32'd3, 32'd4);
    q_rd.push_back(BASE); q_rd.push_back(BASE + 16'd4); q_rd.push_back(BASE + 16'd8);
    q_vld.push_back({3'd0, mem[1]}); q_vld.push_back({3'd1, mem[2]});
    do_reset("s2a");
    for (i = 0; i < 2000; i++) begin
      @(negedge timer_clk);
      if (cfg_word_vld && cfg_word_idx == 3'd1) break;
    end
    check("s2_saw_word1", {31'd0, cfg_word_vld}, 32'd1);
    check("s2_spien_from_w0", {31'd0, spien_bit}, 32'd1);
    repeat (3) @(posedge timer_clk);
    #3;
    por_rst_n = 1'b0;
    #1;
    check("s2_async_clear", {26'd0, por_rd_en, por_vs_en, por_tc_sel, por_clr_dl, spien_bit,
          por_cfg_done}, 32'd0);
    check("s2_async_addr", {16'd0, por_ee_addr}, {16'd0, BASE});
    check("s2_partial_q_empty", q_rd.size() + q_vld.size(), 0);
    q_rd.delete(); q_vld.delete();
    push_attempt(1'b1);
    do_reset("s2b");
    wait_done("s2");
    final_checks("s2", 1'b0, 3'd0, 1'b1);

    // S3: bad magic with test mode; strap valid arrives late
    set_mem(32'd0, 32'd1, 32'd2, 32'd3, 32'd4);
    test_en = 1'b1; spi_en_s = 1'b1; spi_en_s_val = 1'b0;
    q_rd.push_back(BASE);
    do_reset("s3");
    repeat (60) @(negedge timer_clk);
    check("s3_wait_strap", {31'd0, por_cfg_done}, 32'd0);
    spi_en_s_val = 1'b1;
    wait_done("s3");
    final_checks("s3", 1'b0, 3'd0, 1'b1);

    // S4: bad magic without test mode -> retries exhausted
    test_en = 1'b0; spi_en_s = 1'b0; spi_en_s_val = 1'b0;
    for (int a = 0; a < 3; a++) push_attempt(1'b0);
    do_reset("s4");
    wait_done("s4");
    final_checks("s4", 1'b1, 3'd3, 1'b0);

`ifdef POR_CFG_CHECKSUM_EN
    // S5: checksum word forced to zero -> every attempt fails, words re-strobed
    set_mem(MAGIC, 32'd1, 32'd2, 32'd3, 32'd4);
    mem[5] = 32'd0;
    for (int a = 0; a < 3; a++) push_attempt(1'b1);
    do_reset("s5");
    wait_done("s5");
    final_checks("s5", 1'b1, 3'd3, 1'b0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
